// File: rtl/display_pkg.sv
// Shared constants and anode helpers for the seven-segment display path.
package display_pkg;

    localparam int unsigned DEFAULT_SCAN_DIV = 1;

    // Widest anode vector the helpers can build; callers truncate to NUM_DIGITS.
    localparam int unsigned MAX_DIGITS = 32;
    localparam int unsigned MAX_IDX_W  = $clog2(MAX_DIGITS);

    typedef logic [MAX_DIGITS-1:0] anode_vec_t;

    // All anodes inactive for the given digit count and polarity.
    function automatic anode_vec_t anode_off(input int unsigned num_digits,
                                             input bit          active_low);
        anode_vec_t r;
        r = '0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            r[MAX_IDX_W'(i)] = active_low && (i < num_digits);
        end
        return r;
    endfunction

    // One-hot anode drive selecting digit idx, all others inactive.
    function automatic anode_vec_t anode_onehot(input int unsigned idx,
                                                input int unsigned num_digits,
                                                input bit          active_low);
        anode_vec_t r;
        r = anode_off(num_digits, active_low);
        if (idx < num_digits) begin
            r[MAX_IDX_W'(idx)] = !active_low;
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Dwell-time prescaler: counts 0..SCAN_DIV-1 while enabled, flags the last count.
module scan_prescaler #(
    parameter int unsigned SCAN_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_c_o
);

    localparam int unsigned     CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max;

    // Next count and combinational tick; clear dominates enable.
    always_comb begin
        at_max   = (cnt_q == CNT_MAX);
        cnt_d    = cnt_q;
        tick_c_o = en_i && !clr_i && at_max;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_max ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed seven-segment scan driver with frame-coherent snapshot.
// Optional leading-zero blanking is compiled in with DISPLAY_SCAN_LZB_EN.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS       = 4,
    parameter int unsigned DIGIT_W          = 4,
    parameter int unsigned SCAN_DIV         = DEFAULT_SCAN_DIV,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  digits_i,
    input  logic                                enable_i,
    output logic [DIGIT_W-1:0]                  digit_o,
    output logic [NUM_DIGITS-1:0]               anode_o,
    output logic [$clog2(NUM_DIGITS)-1:0]       slot_o,
    output logic                                blank_o,
    output logic                                frame_start_o
);

    localparam int unsigned          SLOT_W    = $clog2(NUM_DIGITS);
    localparam logic [SLOT_W-1:0]    LAST_SLOT = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
        NUM_DIGITS'(anode_off(NUM_DIGITS, ANODE_ACTIVE_LOW));

    logic                               tick_c;
    logic [SLOT_W-1:0]                  cur_q,   cur_d;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] frame_q, frame_d;
    logic [DIGIT_W-1:0]                 digit_q, digit_d;
    logic [SLOT_W-1:0]                  slot_q,  slot_d;
    logic [NUM_DIGITS-1:0]              anode_q, anode_d;
    logic                               blank_q, blank_d;
    logic                               fs_q,    fs_d;

    logic [SLOT_W-1:0]                  nxt_slot;
    logic [SLOT_W-1:0]                  sel_idx;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] src;

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!enable_i),
        .en_i     (enable_i),
        .tick_c_o (tick_c)
    );

    // Slot to enter on the next tick; entering slot 0 reads the live inputs.
    always_comb begin
        nxt_slot = (cur_q == LAST_SLOT) ? '0 : cur_q + 1'b1;
        sel_idx  = LAST_SLOT - nxt_slot;
        src      = (nxt_slot == '0) ? digits_i : frame_q;
    end

`ifdef DISPLAY_SCAN_LZB_EN
    logic lead_zero;

    // Slot is blanked when it and every more-significant snapshot digit are zero.
    always_comb begin
        lead_zero = (nxt_slot != LAST_SLOT);
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if ((j <= 32'(nxt_slot)) && (src[SLOT_W'(NUM_DIGITS - 1 - j)] != '0)) begin
                lead_zero = 1'b0;
            end
        end
    end
`endif

    // Next-state for slot pointer, snapshot and registered outputs.
    always_comb begin
        cur_d   = cur_q;
        frame_d = frame_q;
        digit_d = digit_q;
        slot_d  = slot_q;
        anode_d = anode_q;
        blank_d = blank_q;
        fs_d    = 1'b0;
        if (!enable_i) begin
            cur_d   = LAST_SLOT;
            anode_d = ANODE_OFF;
            blank_d = 1'b1;
        end else if (tick_c) begin
            cur_d   = nxt_slot;
            slot_d  = nxt_slot;
            digit_d = src[sel_idx];
            fs_d    = (nxt_slot == '0);
            if (nxt_slot == '0) begin
                frame_d = digits_i;
            end
            anode_d = NUM_DIGITS'(anode_onehot(32'(sel_idx), NUM_DIGITS, ANODE_ACTIVE_LOW));
            blank_d = 1'b0;
`ifdef DISPLAY_SCAN_LZB_EN
            if (lead_zero) begin
                anode_d = ANODE_OFF;
                blank_d = 1'b1;
            end
`endif
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q   <= LAST_SLOT;
            frame_q <= '0;
            digit_q <= '0;
            slot_q  <= '0;
            anode_q <= ANODE_OFF;
            blank_q <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            cur_q   <= cur_d;
            frame_q <= frame_d;
            digit_q <= digit_d;
            slot_q  <= slot_d;
            anode_q <= anode_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
        end
    end

    assign digit_o       = digit_q;
    assign anode_o       = anode_q;
    assign slot_o        = slot_q;
    assign blank_o       = blank_q;
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: three instances (SCAN_DIV 1, 3, 5) on shared inputs,
// checked against a model driven by the count of enabled edges since the last clear.
module tb_display_scan_mux;

    logic            clk;
    logic            rst;
    logic            en;
    logic [3:0][3:0] digits;

    logic [3:0] dig_o   [3];
    logic [1:0] slot_o  [3];
    logic [3:0] an_o    [3];
    logic       blank_o [3];
    logic       fs_o    [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        display_scan_mux #(
            .NUM_DIGITS       (4),
            .DIGIT_W          (4),
            .SCAN_DIV         (2 * g + 1),
            .ANODE_ACTIVE_LOW (1'b1)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .digits_i      (digits),
            .enable_i      (en),
            .digit_o       (dig_o[g]),
            .anode_o       (an_o[g]),
            .slot_o        (slot_o[g]),
            .blank_o       (blank_o[g]),
            .frame_start_o (fs_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state per instance.
    int          e_m     [3];
    logic [15:0] snap_m  [3];
    logic [3:0]  dig_m   [3];
    logic [1:0]  slot_m  [3];
    logic [3:0]  an_m    [3];
    logic        blank_m [3];
    logic        fs_m    [3];

    function automatic logic [11:0] act(input int k);
        return {dig_o[k], slot_o[k], an_o[k], blank_o[k], fs_o[k]};
    endfunction

    function automatic logic [11:0] expv(input int k);
        return {dig_m[k], slot_m[k], an_m[k], blank_m[k], fs_m[k]};
    endfunction

    // Advance one clock edge and update the model from the inputs seen at that edge.
    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            int d;
            int t;
            int s;
            d = 2 * k + 1;
            if (rst) begin
                e_m[k] = 0; snap_m[k] = 16'h0; dig_m[k] = 4'h0; slot_m[k] = 2'd0;
                an_m[k] = 4'hF; blank_m[k] = 1'b1; fs_m[k] = 1'b0;
            end else if (!en) begin
                e_m[k] = 0; an_m[k] = 4'hF; blank_m[k] = 1'b1; fs_m[k] = 1'b0;
            end else begin
                e_m[k] = e_m[k] + 1;
                fs_m[k] = 1'b0;
                if (e_m[k] % d == 0) begin
                    t = e_m[k] / d;
                    s = (t - 1) % 4;
                    if (s == 0) snap_m[k] = digits;
                    slot_m[k]  = 2'(s);
                    fs_m[k]    = (s == 0);
                    dig_m[k]   = snap_m[k][4 * (3 - s) +: 4];
                    an_m[k]    = 4'(~(4'b0001 << (3 - s)));
                    blank_m[k] = 1'b0;
`ifdef DISPLAY_SCAN_LZB_EN
                    if (s != 3 && (snap_m[k] >> (4 * (3 - s))) == 16'h0) begin
                        an_m[k] = 4'hF;
                        blank_m[k] = 1'b1;
                    end
`endif
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; digits = 16'h3210;
        step(); step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({dig_o[k], slot_o[k], an_o[k], blank_o[k], fs_o[k]} !== {4'h0, 2'd0, 4'hF, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset div=%0d got=%h want=%h", 2 * k + 1, act(k), {4'h0, 2'd0, 4'hF, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_basic_rotation();
        logic [3:0] one;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            one = 4'b1000 >> (i % 4);
            checks++;
            if ({dig_o[0], an_o[0], fs_o[0]} !== {4'(3 - i % 4), 4'(~one), 1'(i % 4 == 0)}) begin
                errors++;
                $display("FAIL rotation cyc=%0d got=%h want=%h", i, {dig_o[0], an_o[0], fs_o[0]},
                         {4'(3 - i % 4), 4'(~one), 1'(i % 4 == 0)});
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL rotation_model div=%0d got=%h want=%h", 2 * k + 1, act(k), expv(k));
                end
            end
        end
    endtask

    task automatic test_dwell();
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            step();
            checks++;
            if ({fs_o[2], blank_o[2]} !== {1'(i == 5 || i == 25), 1'(i < 5)}) begin
                errors++;
                $display("FAIL dwell_fs edge=%0d got=%b want=%b", i, {fs_o[2], blank_o[2]},
                         {1'(i == 5 || i == 25), 1'(i < 5)});
            end
            if (i >= 5) begin
                checks++;
                if (slot_o[2] !== 2'(((i - 5) / 5) % 4)) begin
                    errors++;
                    $display("FAIL dwell_slot edge=%0d got=%0d want=%0d", i, slot_o[2], ((i - 5) / 5) % 4);
                end
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL dwell_model div=%0d got=%h want=%h", 2 * k + 1, act(k), expv(k));
                end
            end
        end
    endtask

    task automatic test_snapshot();
        logic [3:0] seq [5];
        bit found;
        seq = '{4'h4, 4'hA, 4'hB, 4'hC, 4'hD};
        rst = 1'b1; step(); rst = 1'b0;
        digits = 16'h1234;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (slot_o[0] == 2'd2 && blank_o[0] == 1'b0) found = 1'b1;
        end
        checks++;
        if (!found || dig_o[0] !== 4'h3) begin
            errors++;
            $display("FAIL snapshot_slot2 found=%0d got=%h want=3", found, dig_o[0]);
        end
        digits = 16'hABCD;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (dig_o[0] !== seq[i]) begin
                errors++;
                $display("FAIL snapshot_seq idx=%0d got=%h want=%h", i, dig_o[0], seq[i]);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL snapshot_model div=%0d got=%h want=%h", 2 * k + 1, act(k), expv(k));
                end
            end
        end
    endtask

    task automatic test_enable();
        bit found;
        logic [3:0] held;
        int first [3];
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (slot_o[0] == 2'd1 && blank_o[0] == 1'b0) found = 1'b1;
        end
        held = dig_o[0];
        en = 1'b0;
        step();
        checks++;
        if (!found || {an_o[0], blank_o[0], slot_o[0], dig_o[0]} !== {4'hF, 1'b1, 2'd1, held}) begin
            errors++;
            $display("FAIL disable found=%0d got=%h want=%h", found, {an_o[0], blank_o[0], slot_o[0], dig_o[0]},
                     {4'hF, 1'b1, 2'd1, held});
        end
        step(); step();
        en = 1'b1;
        first = '{0, 0, 0};
        for (int i = 1; i <= 6; i++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                if (fs_o[k] && first[k] == 0) first[k] = i;
                checks++;
                if (act(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL enable_model div=%0d got=%h want=%h", 2 * k + 1, act(k), expv(k));
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (first[k] !== 2 * k + 1) begin
                errors++;
                $display("FAIL reenable_latency div=%0d got=%0d want=%0d", 2 * k + 1, first[k], 2 * k + 1);
            end
        end
    endtask

    task automatic test_rst_mid();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (slot_o[1] == 2'd2 && blank_o[1] == 1'b0) found = 1'b1;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (!found || act(k) !== {4'h0, 2'd0, 4'hF, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL rst_mid div=%0d found=%0d got=%h want=%h", 2 * k + 1, found, act(k),
                         {4'h0, 2'd0, 4'hF, 1'b1, 1'b0});
            end
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if ({fs_o[1], blank_o[1], slot_o[1]} !== {1'(i == 3), 1'(i < 3), 2'd0}) begin
                errors++;
                $display("FAIL rst_restart edge=%0d got=%b want=%b", i, {fs_o[1], blank_o[1], slot_o[1]},
                         {1'(i == 3), 1'(i < 3), 2'd0});
            end
        end
    endtask

    task automatic test_lzb();
        logic [3:0] exp_dig;
        logic       exp_blank;
        rst = 1'b1; step(); rst = 1'b0;
        digits = 16'h0050;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) digits = 16'h0000;
            step();
            exp_dig = (i < 8 && i % 4 == 2) ? 4'h5 : 4'h0;
`ifdef DISPLAY_SCAN_LZB_EN
            exp_blank = (i < 8) ? (i % 4 < 2) : (i % 4 != 3);
`else
            exp_blank = 1'b0;
`endif
            checks++;
            if ({dig_o[0], blank_o[0]} !== {exp_dig, exp_blank}) begin
                errors++;
                $display("FAIL lzb cyc=%0d got=%h want=%h", i, {dig_o[0], blank_o[0]}, {exp_dig, exp_blank});
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL lzb_model div=%0d got=%h want=%h", 2 * k + 1, act(k), expv(k));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            digits = 16'($urandom);
            en     = ($urandom_range(0, 9) != 0);
            rst    = ($urandom_range(0, 99) == 0);
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL random cyc=%0d div=%0d got=%h want=%h", i, 2 * k + 1, act(k), expv(k));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; digits = 16'h0;
        test_reset();
        test_basic_rotation();
        test_dwell();
        test_snapshot();
        test_enable();
        test_rst_mid();
        test_lzb();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Parametrised time-multiplexed scan driver for the multi-digit seven-segment display path. Replaces the fixed 4×4-bit rotating digit selector with a configurable number of digits and digit width, and a programmable per-digit dwell time. Adds one-hot anode drive, a frame-coherent input snapshot and an enable/blank control. It sits between the numeric/BCD datapath and the segment decoder, which consumes `digit_o` and `blank_o`.

## Interface
- `NUM_DIGITS`, 4: digits scanned; legal range ≥2.
- `DIGIT_W`, 4: bits per digit.
- `SCAN_DIV`, 1: clk cycles each digit is held; legal range ≥1. A value of 1 reproduces the legacy one-digit-per-clock rotation.
- `ANODE_ACTIVE_LOW`, 1: 1 = the active anode is driven 0; 0 = driven 1.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `digits_i`  in  [NUM_DIGITS-1:0][DIGIT_W-1:0]  digit values; index NUM_DIGITS-1 = MSB.
- `enable_i`  in  1  scan enable.
- `digit_o`  out  DIGIT_W  value of the currently displayed digit.
- `anode_o`  out  NUM_DIGITS  one-hot anode select, polarity set by ANODE_ACTIVE_LOW; bit k drives digits_i[k].
- `slot_o`  out  $clog2(NUM_DIGITS)  displayed slot; slot 0 = MSB.
- `blank_o`  out  1  1 = segments must be off.
- `frame_start_o`  out  1  one-cycle pulse when slot 0 is loaded.

## Operation
- Prescaler `cnt` counts 0..SCAN_DIV-1 and wraps. `tick` = (cnt == SCAN_DIV-1) && enable_i.
- Internal slot register `cur` resets to NUM_DIGITS-1. On `tick`, `cur` advances to cur+1, or wraps from NUM_DIGITS-1 to 0.
- Slot s displays `frame_q[NUM_DIGITS-1-s]`, so the MSB is shown first.
- On the tick that enters slot 0: `frame_q` <= digits_i, and `digit_o` takes its value from digits_i directly. All slots of one frame therefore show a single coherent snapshot.
- All outputs are registered and update only on the tick edge. Between ticks they hold.
- `enable_i` low, sampled on any edge, takes effect on the next edge:
  - `cnt` <= 0 and `cur` <= NUM_DIGITS-1.
  - `anode_o` all inactive, `blank_o` = 1, `digit_o` and `slot_o` hold.
- When `enable_i` rises again, slot 0 is loaded SCAN_DIV cycles later.
- Reset values:
  - `digit_o` = 0, `slot_o` = 0, `frame_start_o` = 0, `blank_o` = 1.
  - `anode_o` all inactive: all-ones if ANODE_ACTIVE_LOW, else all-zeros.
  - `cnt` = 0, `cur` = NUM_DIGITS-1, `frame_q` = 0.
- `rst` mid-frame aborts the scan immediately. No partial-frame state survives.

## Timing
- First slot 0 after reset release with `enable_i` = 1: outputs valid at edge SCAN_DIV. `frame_start_o` is high for exactly that one cycle.
- Dwell per slot: exactly SCAN_DIV cycles. Frame period: NUM_DIGITS·SCAN_DIV cycles.
- Latency from a `digits_i` change to display: up to the next frame start, plus 0 cycles beyond that edge.
- With SCAN_DIV = 1, `tick` is asserted every enabled cycle and the slot changes every clock.
- Simultaneous `rst` and `enable_i`: `rst` wins.
- Simultaneous `tick` and `enable_i` falling cannot occur, because `tick` is gated by `enable_i`.

## Configuration
- `DISPLAY_SCAN_LZB_EN` defined: leading-zero blanking is compiled in.
  - A slot is blanked when its snapshot digit and every more-significant snapshot digit are 0.
  - A blanked slot drives all anodes inactive and `blank_o` = 1. Its dwell time and `frame_start_o` are unchanged.
  - The LSB slot (NUM_DIGITS-1) is never blanked.
  - The blanking decision uses `frame_q`, or digits_i on the slot-0 load edge.
- Macro undefined: no blanking logic. `blank_o` = 1 only in reset or while disabled.

## Structure
- Shared `display_pkg` holds:
  - `DEFAULT_SCAN_DIV` constant.
  - Anode-inactive helper function `anode_off(NUM_DIGITS, ANODE_ACTIVE_LOW)`.
  - One-hot anode encoder function.
- One sub-module, `scan_prescaler`: SCAN_DIV counter with synchronous clear and enable; outputs `tick`.

## Test plan
- Reset, NUM_DIGITS=4, SCAN_DIV=1, digits_i = {4'h3, 4'h2, 4'h1, 4'h0}:
  - `digit_o` sequence 3, 2, 1, 0, 3, … one value per clock.
  - Active-low `anode_o` = 0111, 1011, 1101, 1110.
  - `frame_start_o` high once every 4 cycles.
- SCAN_DIV=5: each slot is held exactly 5 cycles, and first slot 0 appears at edge 5 after reset release.
- Change digits_i from 0x1234 to 0xABCD while slot 2 is displayed: the remaining slots of that frame still show 3, 4, and the next frame shows A, B, C, D.
- Drop `enable_i` for 3 cycles during slot 1:
  - Next edge: anodes all 1, `blank_o` = 1.
  - After re-enable: slot 0 reloads after SCAN_DIV cycles, and `frame_start_o` pulses.
- With `DISPLAY_SCAN_LZB_EN` defined, digits_i = 0x0050: slots 0 and 1 are blanked, slot 2 shows 5, slot 3 shows 0. digits_i = 0x0000: only slot 3 is shown, value 0.
- Assert `rst` mid-frame at slot 2, SCAN_DIV = 3: all outputs return to their reset values on the next edge, and scanning restarts at slot 0.
